ps2_move_decoder: RTL and testbench

//  Receives PS/2 keyboard frames on ps2_clk/ps2_data and decodes scan code set 2 make/break sequences.

---
 rtl/ps2_move_decoder_pkg.sv | 82 ++++++++
 rtl/ps2_move_decoder_frame_rx.sv | 127 ++++++++++++
 rtl/ps2_move_decoder.sv | 106 ++++++++++
 tb/tb_ps2_move_decoder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_move_decoder_pkg.sv
// Shared constants, decode-state type and key-map helpers for the PS/2 move decoder.
package ps2_move_decoder_pkg;

  // Move strobe encoding
  localparam logic [2:0] MOVE_NONE    = 3'd0;
  localparam logic [2:0] MOVE_UP      = 3'd1;
  localparam logic [2:0] MOVE_DOWN    = 3'd2;
  localparam logic [2:0] MOVE_LEFT    = 3'd3;
  localparam logic [2:0] MOVE_RIGHT   = 3'd4;
  localparam logic [2:0] MOVE_CONFIRM = 3'd5;

  // Scan code set 2 prefixes
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // Plain keys
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_SPACE = 8'h29;

  // Extended (E0-prefixed) arrow keys
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  // Index of the stop bit within a frame (start = 0, d0..d7 = 1..8, parity = 9)
  localparam logic [3:0] FRAME_STOP_IDX   = 4'd10;
  localparam logic [3:0] FRAME_PARITY_IDX = 4'd9;
  localparam logic [3:0] FRAME_LAST_DATA  = 4'd8;

  typedef enum logic [1:0] {
    StIdle,
    StExt,
    StBrk,
    StExtBrk
  } dec_state_e;

  // Map a scan code (with its extended flag) to a move; unmapped keys give MOVE_NONE.
  function automatic logic [2:0] key_map(input logic [7:0] code, input logic ext);
    logic [2:0] m;
    m = MOVE_NONE;
    if (!ext) begin
      case (code)
        SC_W:     m = MOVE_UP;
        SC_S:     m = MOVE_DOWN;
        SC_A:     m = MOVE_LEFT;
        SC_D:     m = MOVE_RIGHT;
        SC_ENTER: m = MOVE_CONFIRM;
        SC_SPACE: m = MOVE_CONFIRM;
        default:  m = MOVE_NONE;
      endcase
    end else begin
      case (code)
        SC_UP:    m = MOVE_UP;
        SC_DOWN:  m = MOVE_DOWN;
        SC_LEFT:  m = MOVE_LEFT;
        SC_RIGHT: m = MOVE_RIGHT;
        default:  m = MOVE_NONE;
      endcase
    end
    return m;
  endfunction

  // One-hot held-bit mask for a move; bit 0 corresponds to MOVE_UP.
  function automatic logic [4:0] move_mask(input logic [2:0] m);
    logic [4:0] mask;
    case (m)
      MOVE_UP:      mask = 5'b00001;
      MOVE_DOWN:    mask = 5'b00010;
      MOVE_LEFT:    mask = 5'b00100;
      MOVE_RIGHT:   mask = 5'b01000;
      MOVE_CONFIRM: mask = 5'b10000;
      default:      mask = 5'b00000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/ps2_move_decoder_frame_rx.sv
// PS/2 frame receiver: pin synchronizers, falling-edge detect, 11-bit framing,
// odd-parity check and mid-frame timeout.
module ps2_frame_rx
  import ps2_move_decoder_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] scan_code_o,
  output logic       scan_valid_o,
  output logic       frame_err_o
);

  localparam int unsigned ToW = $clog2(TIMEOUT_CYC + 1);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   clk_prev_q;
  logic                   data_dly_q;
  logic                   fall_q;
  logic                   clk_s;

  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           parity_q, parity_d;
  logic [ToW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]     code_q, code_d;
  logic           valid_q, valid_d;
  logic           err_q, err_d;

  assign clk_s = clk_sync_q[SYNC_STAGES-1];

  // Synchronize the pins and register the ps2_clk falling edge; data is delayed to stay aligned.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
      data_dly_q  <= 1'b1;
      fall_q      <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
      clk_prev_q  <= clk_s;
      data_dly_q  <= data_sync_q[SYNC_STAGES-1];
      fall_q      <= clk_prev_q & ~clk_s;
    end
  end

  // Frame assembly, checking and timeout; a fall always takes priority over the timeout.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    to_cnt_d  = to_cnt_q;
    code_d    = code_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;

    if (fall_q) begin
      to_cnt_d = '0;
      if (bit_cnt_q == 4'd0) begin
        // A high start bit is rejected without leaving the idle position.
        if (data_dly_q) begin
          err_d = 1'b1;
        end else begin
          bit_cnt_d = 4'd1;
        end
      end else if (bit_cnt_q <= FRAME_LAST_DATA) begin
        shift_d   = {data_dly_q, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end else if (bit_cnt_q == FRAME_PARITY_IDX) begin
        parity_d  = data_dly_q;
        bit_cnt_d = FRAME_STOP_IDX;
      end else begin
        bit_cnt_d = 4'd0;
        // Odd parity: data plus parity bit must hold an odd number of ones.
        if (data_dly_q && (^{shift_q, parity_q})) begin
          code_d  = shift_q;
          valid_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (to_cnt_q == ToW'(TIMEOUT_CYC - 1)) begin
        to_cnt_d  = '0;
        bit_cnt_d = 4'd0;
        err_d     = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end else begin
      to_cnt_d = '0;
    end
  end

  // Receiver state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bit_cnt_q <= 4'd0;
      shift_q   <= 8'h00;
      parity_q  <= 1'b0;
      to_cnt_q  <= '0;
      code_q    <= 8'h00;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      to_cnt_q  <= to_cnt_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign scan_code_o  = code_q;
  assign scan_valid_o = valid_q;
  assign frame_err_o  = err_q;

endmodule

// File: rtl/ps2_move_decoder.sv
// PS/2 keyboard to game-move decoder: make/break decode, key map and typematic suppression.
module ps2_move_decoder
  import ps2_move_decoder_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [2:0] move,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err
);

  logic [7:0] rx_code;
  logic       rx_valid;
  logic       rx_err;

  dec_state_e state_q, state_d;
  logic [4:0] held_q, held_d;
  logic [2:0] move_q, move_d;
  logic [2:0] key_move;
  logic [4:0] key_mask;
  logic       is_ext;
  logic       do_make;

  ps2_frame_rx #(
    .SYNC_STAGES(SYNC_STAGES),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_frame_rx (
    .clk_i       (clk),
    .rst_i       (rst),
    .ps2_clk_i   (ps2_clk),
    .ps2_data_i  (ps2_data),
    .scan_code_o (rx_code),
    .scan_valid_o(rx_valid),
    .frame_err_o (rx_err)
  );

  assign is_ext   = (state_q == StExt) || (state_q == StExtBrk);
  assign key_move = key_map(rx_code, is_ext);
  assign key_mask = move_mask(key_move);

  // Decode make/break prefixes on each received byte; strobe only the first make of a held key.
  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    move_d  = MOVE_NONE;
    do_make = 1'b0;

    if (rx_valid) begin
      unique case (state_q)
        StIdle: begin
          if (rx_code == PS2_EXT) begin
            state_d = StExt;
          end else if (rx_code == PS2_BRK) begin
            state_d = StBrk;
          end else begin
            do_make = 1'b1;
          end
        end
        StExt: begin
          if (rx_code == PS2_BRK) begin
            state_d = StExtBrk;
          end else if (rx_code != PS2_EXT) begin
            do_make = 1'b1;
            state_d = StIdle;
          end
        end
        StBrk, StExtBrk: begin
          held_d  = held_q & ~key_mask;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end

    // key_mask is zero for unmapped keys, so they never strobe.
    if (do_make && (key_mask != 5'b0) && ((held_q & key_mask) == 5'b0)) begin
      move_d = key_move;
      held_d = held_q | key_mask;
    end
  end

  // Decode state, held keys and the registered move strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      held_q  <= 5'b0;
      move_q  <= MOVE_NONE;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      move_q  <= move_d;
    end
  end

  assign move       = move_q;
  assign scan_code  = rx_code;
  assign scan_valid = rx_valid;
  assign frame_err  = rx_err;

endmodule

// File: tb/tb_ps2_move_decoder.sv
// Self-checking bench for ps2_move_decoder with a byte-level model of the key decoder.
module tb_ps2_move_decoder;

  localparam int unsigned TO = 300;  // scaled-down timeout, PS/2 bit period is 40 clk cycles

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [2:0] move;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       frame_err;

  ps2_move_decoder #(
    .SYNC_STAGES(2),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .move      (move),
    .scan_code (scan_code),
    .scan_valid(scan_valid),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int strobes[8];
  int err_cnt = 0;
  int sv_cnt = 0;
  logic [7:0] exp_q[$];

  // Model state: pending prefixes and which moves are currently held down.
  bit m_ext = 0;
  bit m_brk = 0;
  bit m_held[8];
  logic [2:0] exp_move = 3'd0;
  bit chk_move = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] key_of(input logic [7:0] b, input bit ext);
    if (!ext) begin
      if (b == 8'h1D) return 3'd1;
      if (b == 8'h1B) return 3'd2;
      if (b == 8'h1C) return 3'd3;
      if (b == 8'h23) return 3'd4;
      if (b == 8'h5A || b == 8'h29) return 3'd5;
    end else begin
      if (b == 8'h75) return 3'd1;
      if (b == 8'h72) return 3'd2;
      if (b == 8'h6B) return 3'd3;
      if (b == 8'h74) return 3'd4;
    end
    return 3'd0;
  endfunction

  // Apply one received byte to the model; returns the move that must appear one cycle later.
  function logic [2:0] model_byte(input logic [7:0] b);
    logic [2:0] k;
    if (!m_brk && b == 8'hE0) begin
      m_ext = 1;
      return 3'd0;
    end
    if (!m_brk && b == 8'hF0) begin
      m_brk = 1;
      return 3'd0;
    end
    k = key_of(b, m_ext);
    model_byte = 3'd0;
    if (m_brk) begin
      m_held[k] = 0;
    end else if (k != 3'd0 && !m_held[k]) begin
      m_held[k] = 1;
      model_byte = k;
    end
    m_ext = 0;
    m_brk = 0;
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [7:0] b;
    if (rst) begin
      m_ext = 0;
      m_brk = 0;
      for (int i = 0; i < 8; i++) m_held[i] = 0;
      chk_move = 0;
    end else begin
      if (chk_move) check("move_strobe", int'(move), int'(exp_move));
      else check("move_quiet", int'(move), 0);
      chk_move = 0;
      if (move != 3'd0) strobes[move]++;
      if (frame_err) err_cnt++;
      if (scan_valid) begin
        sv_cnt++;
        check("scan_valid_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          b = exp_q.pop_front();
          check("scan_code", int'(scan_code), int'(b));
          exp_move = model_byte(b);
          chk_move = 1;
        end
      end
    end
  end

  task automatic ps2_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (20) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    logic par;
    par = ~^b;
    if (bad_par) par = ~par;
    else exp_q.push_back(b);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(1'b1);
    repeat (40) @(negedge clk);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    ps2_bit(1'b0);
    for (int i = 0; i < nbits - 1; i++) ps2_bit(b[i]);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_move", int'(move), 0);
    check("rst_scan_code", int'(scan_code), 0);
    check("rst_scan_valid", int'(scan_valid), 0);
    check("rst_frame_err", int'(frame_err), 0);
    rst = 1'b0;
  endtask

  initial begin
    int e0, s0;
    for (int i = 0; i < 8; i++) strobes[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_move", int'(move), 0);
    check("reset_scan_code", int'(scan_code), 0);
    check("reset_scan_valid", int'(scan_valid), 0);
    check("reset_frame_err", int'(frame_err), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 1: W press then release -> one up strobe
    send_frame(8'h1D, 0);
    send_frame(8'hF0, 0);
    send_frame(8'h1D, 0);
    check("t1_up_count", strobes[1], 1);

    // 2: typematic Left, release, press again -> two left strobes
    for (int i = 0; i < 3; i++) begin
      send_frame(8'hE0, 0);
      send_frame(8'h6B, 0);
    end
    send_frame(8'hE0, 0);
    send_frame(8'hF0, 0);
    send_frame(8'h6B, 0);
    send_frame(8'hE0, 0);
    send_frame(8'h6B, 0);
    check("t2_left_count", strobes[3], 2);
    send_frame(8'hE0, 0);
    send_frame(8'hF0, 0);
    send_frame(8'h6B, 0);

    // 3: bad parity on 1C, then a good 1C
    e0 = err_cnt;
    s0 = sv_cnt;
    send_frame(8'h1C, 1);
    check("t3_parity_err", err_cnt - e0, 1);
    check("t3_no_valid", sv_cnt - s0, 0);
    check("t3_no_strobe", strobes[3], 2);
    send_frame(8'h1C, 0);
    check("t3_left_count", strobes[3], 3);
    send_frame(8'hF0, 0);
    send_frame(8'h1C, 0);

    // 4: clock stalls after 4 bits -> timeout error, then a good 5A
    e0 = err_cnt;
    send_partial(8'h5A, 4);
    repeat (TO + TO / 2) @(negedge clk);
    check("t4_timeout_err", err_cnt - e0, 1);
    send_frame(8'h5A, 0);
    check("t4_confirm_count", strobes[5], 1);

    // 5: hold D, reset mid-frame, then E0 74 strobes right again because held was cleared
    send_frame(8'h23, 0);
    check("t5_right_first", strobes[4], 1);
    send_partial(8'h74, 6);
    pulse_reset();
    repeat (40) @(negedge clk);
    send_frame(8'hE0, 0);
    send_frame(8'h74, 0);
    check("t5_right_after_rst", strobes[4], 2);

    // 6: unmapped 15 and E0 12 -> bytes arrive, no strobe; decoder back in idle for W
    s0 = sv_cnt;
    send_frame(8'h15, 0);
    send_frame(8'hE0, 0);
    send_frame(8'h12, 0);
    check("t6_valid_count", sv_cnt - s0, 3);
    check("t6_no_strobe", strobes[1] + strobes[2] + strobes[3] + strobes[4] + strobes[5], 7);
    send_frame(8'h1D, 0);
    check("t6_up_after_idle", strobes[1], 2);

    check("all_frames_seen", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
